// File: rtl/cnn_mac_pkg.sv
// Shared definitions for multiply_acc users: default MAC pipeline depth and accumulator sizing.
// ACC_WIDTH gives the exact accumulator width for a given pair of operand widths.
package cnn_mac_pkg;

  localparam int MAC_LATENCY_DEF = 5;

  function automatic int ACC_WIDTH(input int img_w, input int ker_w);
    return img_w + ker_w + 1;
  endfunction

  localparam int ACC_WIDTH_DEF = ACC_WIDTH(16, 16);

  typedef logic [ACC_WIDTH_DEF-1:0] acc_word_t;

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous FIFO with a registered head word, DEPTH x WIDTH.
// head_dat_o is valid whenever empty_o is low; entries behind the head sit in a circular buffer.
module mac_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_vld_q, head_vld_d;

  logic pop, head_free, mem_empty, load_mem, load_push, write_mem;

  always_comb begin
    pop        = pop_i && head_vld_q;
    head_free  = !head_vld_q || pop;
    mem_empty  = (mem_cnt_q == '0);
    load_mem   = head_free && !mem_empty;
    // A push into an idle head bypasses the buffer, so a pop+push at occupancy 1 has no bubble.
    load_push  = head_free && mem_empty && push_i;
    write_mem  = push_i && !load_push;

    head_d     = head_q;
    head_vld_d = head_vld_q;
    if (load_mem) begin
      head_d     = mem_q[rd_ptr_q];
      head_vld_d = 1'b1;
    end else if (load_push) begin
      head_d     = push_dat_i;
      head_vld_d = 1'b1;
    end else if (pop) begin
      head_vld_d = 1'b0;
    end

    wr_ptr_d  = write_mem ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = load_mem ? rd_ptr_q + PW'(1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + CW'(write_mem) - CW'(load_mem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_mem) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = head_q;
  assign empty_o    = !head_vld_q;
  assign count_o    = mem_cnt_q + CW'(head_vld_q);

endmodule

// File: rtl/mac_result_reader.sv
// Turns group-end markers plus the free-running MAC accumulator into per-group sums on a valid/ready stream.
// Optional MAC_READER_RELU_EN clamps negative group sums to zero; MAC_LATENCY must be >= 2.
module mac_result_reader
  import cnn_mac_pkg::*;
#(
  parameter int IMG_WIDTH   = 16,
  parameter int KER_WIDTH   = 16,
  parameter int MAC_LATENCY = MAC_LATENCY_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      issue_last,
  output logic                                      issue_rdy,
  input  logic [ACC_WIDTH(IMG_WIDTH, KER_WIDTH)-1:0] mac_result,
  output logic [ACC_WIDTH(IMG_WIDTH, KER_WIDTH)-1:0] out_data,
  output logic                                      out_val,
  input  logic                                      out_rdy
);

  localparam int              AW      = ACC_WIDTH(IMG_WIDTH, KER_WIDTH);
  localparam int              CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  logic [MAC_LATENCY-1:0] mark_q, mark_d;
  logic [AW-1:0]          prev_q, prev_d;
  logic [CW-1:0]          outst_q, outst_d;
  logic [AW-1:0]          delta, push_dat;
  logic [CW-1:0]          fifo_count;
  logic                   accept, strobe, pop, fifo_empty;

  // Credit covers markers still in the delay line, so the FIFO can never overflow on a strobe.
  assign issue_rdy = outst_q < DEPTH_C;
  assign accept    = issue_last && issue_rdy;
  assign strobe    = mark_q[MAC_LATENCY-1];
  assign out_val   = !fifo_empty;
  assign pop       = out_val && out_rdy;

  always_comb begin
    mark_d = {mark_q[MAC_LATENCY-2:0], accept};
    prev_d = strobe ? mac_result : prev_q;
    delta  = mac_result - prev_q;
`ifdef MAC_READER_RELU_EN
    push_dat = delta[AW-1] ? '0 : delta;
`else
    push_dat = delta;
`endif
    outst_d = outst_q;
    if (accept && !pop) begin
      outst_d = outst_q + CW'(1);
    end else if (!accept && pop) begin
      outst_d = outst_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mark_q  <= '0;
      prev_q  <= '0;
      outst_q <= '0;
    end else begin
      mark_q  <= mark_d;
      prev_q  <= prev_d;
      outst_q <= outst_d;
    end
  end

  mac_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (strobe),
    .push_dat_i (push_dat),
    .pop_i      (out_rdy),
    .head_dat_o (out_data),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  push_never_full: assert property (@(posedge clk) disable iff (!rst)
    strobe |-> (fifo_count < DEPTH_C));

endmodule

// File: tb/tb_mac_result_reader.sv
// Bench: behavioural MAC feeding mac_result_reader, with a group-sum scoreboard and credit model.
module tb_mac_result_reader;
  import cnn_mac_pkg::*;

  localparam int W   = 16;
  localparam int L   = MAC_LATENCY_DEF;
  localparam int D   = 4;
  localparam int AW  = ACC_WIDTH(W, W);
  localparam int W5  = 4;
  localparam int AW5 = ACC_WIDTH(W5, W5);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  // ---------------- instance under main test (16-bit operands)
  logic signed [W-1:0]  img, ker;
  logic                 val, last, out_rdy, mval;
  logic                 issue_rdy, out_val;
  acc_word_t            mac_result, out_data;
  logic signed [AW-1:0] prod;
  logic [AW-1:0]        acc;
  logic [AW-1:0]        pipe [L-1];

  assign mval = val && (!last || issue_rdy);
  assign prod = AW'(img) * AW'(ker);
  assign mac_result = pipe[L-2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      for (int i = 0; i < L-1; i++) pipe[i] <= '0;
    end else begin
      if (mval) acc <= acc + prod;
      pipe[0] <= acc;
      for (int i = 1; i < L-1; i++) pipe[i] <= pipe[i-1];
    end
  end

  mac_result_reader #(.IMG_WIDTH(W), .KER_WIDTH(W), .MAC_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .issue_last(last), .issue_rdy(issue_rdy),
    .mac_result(mac_result), .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy)
  );

  // ---------------- narrow instance for accumulator wrap
  logic signed [W5-1:0]  img5, ker5;
  logic                  val5, last5, rdy5, mval5;
  logic                  issue_rdy5, out_val5;
  logic [AW5-1:0]        mac5, out_data5, acc5;
  logic signed [AW5-1:0] prod5;
  logic [AW5-1:0]        pipe5 [L-1];

  assign mval5 = val5 && (!last5 || issue_rdy5);
  assign prod5 = AW5'(img5) * AW5'(ker5);
  assign mac5  = pipe5[L-2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc5 <= '0;
      for (int i = 0; i < L-1; i++) pipe5[i] <= '0;
    end else begin
      if (mval5) acc5 <= acc5 + prod5;
      pipe5[0] <= acc5;
      for (int i = 1; i < L-1; i++) pipe5[i] <= pipe5[i-1];
    end
  end

  mac_result_reader #(.IMG_WIDTH(W5), .KER_WIDTH(W5), .MAC_LATENCY(L), .FIFO_DEPTH(D)) dut5 (
    .clk(clk), .rst(rst), .issue_last(last5), .issue_rdy(issue_rdy5),
    .mac_result(mac5), .out_data(out_data5), .out_val(out_val5), .out_rdy(rdy5)
  );

  // ---------------- checking helpers and reference model
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] relu(input logic [AW-1:0] x);
`ifdef MAC_READER_RELU_EN
    return x[AW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  logic [AW-1:0]  exp_q [$];
  logic [AW-1:0]  got_q [$];
  logic [AW5-1:0] got5_q [$];
  logic [AW-1:0]  gsum = '0;
  int             outst = 0;
  logic           hold_pend = 1'b0;
  logic [AW-1:0]  hold_dat = '0;

  // Group sum = plain sum of every product the MAC took since the last accepted marker.
  always @(negedge clk) begin
    if (rst) begin
      chk("credit_rdy", issue_rdy, outst < D);
      if (hold_pend) begin
        chk("hold_val", out_val, 1'b1);
        chk("hold_dat", out_data, hold_dat);
      end
      if (mval) gsum = gsum + prod;
      if (last && issue_rdy) begin
        exp_q.push_back(relu(gsum));
        gsum = '0;
        outst++;
      end
      if (out_val && out_rdy) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got 0x%0h with no group outstanding", out_data);
        end else begin
          chk("order_dat", out_data, exp_q.pop_front());
        end
        outst--;
      end
      hold_pend = out_val && !out_rdy;
      hold_dat  = out_data;
      if (out_val5 && rdy5) got5_q.push_back(out_data5);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int i, input int k, input logic l);
    val  = v;
    img  = W'(i);
    ker  = W'(k);
    last = l;
  endtask

  task automatic wait_got(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL wait_got: got %0d results required %0d", got_q.size(), n);
    end
  endtask

  task automatic chk_got(input string nm, input int idx, input int exp);
    if (got_q.size() > idx) chk(nm, got_q[idx], AW'(exp));
    else chk(nm, 64'hdead, AW'(exp));
  endtask

  typedef struct {
    logic v; int i; int k; logic l; logic ordy;
    logic ev; int ed; logic er;
  } vec_t;
  vec_t tv [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic accepted;
    int   c;
    logic [AW-1:0] exp_a;

    drive(0, 0, 0, 0);
    out_rdy = 1'b1;
    img5 = '0; ker5 = '0; val5 = 1'b0; last5 = 1'b0; rdy5 = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_out_val", out_val, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_issue_rdy", issue_rdy, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // 1: single beat 3*4, result 12 exactly at t=6, gone at t=7
    for (int i = 0; i < 8; i++) tv[i] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tv[0] = '{1'b1, 3, 4, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tv[6] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].v, tv[i].i, tv[i].k, tv[i].l);
      out_rdy = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("t1_val[%0d]", i), out_val, tv[i].ev);
      if (tv[i].ev) chk($sformatf("t1_dat[%0d]", i), out_data, AW'(tv[i].ed));
      chk($sformatf("t1_rdy[%0d]", i), issue_rdy, tv[i].er);
      tick();
    end

    // 2: (2*5)+(-3*7) then (1*1)
    got_q.delete();
    drive(1, 2, 5, 0);  tick();
    drive(1, -3, 7, 1); tick();
    drive(1, 1, 1, 1);  tick();
    drive(0, 0, 0, 0);
    wait_got(2, 30);
`ifdef MAC_READER_RELU_EN
    exp_a = '0;
`else
    exp_a = AW'(-11);
`endif
    if (got_q.size() > 0) chk("t2_a", got_q[0], exp_a);
    else chk("t2_a", 64'hdead, exp_a);
    chk_got("t2_b", 1, 1);
    repeat (4) tick();

    // 4: empty group between 7 and 9
    got_q.delete();
    drive(1, 7, 1, 1); tick();
    drive(0, 0, 0, 1); tick();
    drive(1, 9, 1, 1); tick();
    drive(0, 0, 0, 0);
    wait_got(3, 30);
    chk_got("t4_a", 0, 7);
    chk_got("t4_b", 1, 0);
    chk_got("t4_c", 2, 9);
    repeat (4) tick();

    // 3: credit exhaustion with downstream stalled
    got_q.delete();
    out_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, 1, 1);
      @(negedge clk);
      chk($sformatf("t3_rdy_pre%0d", k), issue_rdy, 1'b1);
      tick();
    end
    drive(1, 5, 1, 1);
    repeat (8) begin
      @(negedge clk);
      chk("t3_stall_rdy", issue_rdy, 1'b0);
      tick();
    end
    out_rdy = 1'b1;
    accepted = 1'b0;
    c = 0;
    while (!accepted && c < 20) begin
      @(negedge clk);
      accepted = issue_rdy;
      tick();
      c++;
    end
    chk("t3_fifth_accepted", accepted, 1'b1);
    drive(0, 0, 0, 0);
    wait_got(5, 40);
    for (int k = 0; k < 5; k++) chk_got($sformatf("t3_out%0d", k), k, k + 1);
    repeat (4) tick();

    // 5: narrow accumulator wraps: 40 x 64 = 2560 = 0 mod 512, then 1
    got5_q.delete();
    for (int j = 0; j < 40; j++) begin
      val5 = 1'b1; img5 = -4'sd8; ker5 = -4'sd8; last5 = (j == 39);
      tick();
    end
    val5 = 1'b1; img5 = 4'sd1; ker5 = 4'sd1; last5 = 1'b1;
    tick();
    val5 = 1'b0; last5 = 1'b0;
    c = 0;
    while (got5_q.size() < 2 && c < 30) begin
      tick();
      c++;
    end
    chk("t5_count", got5_q.size(), 2);
    if (got5_q.size() >= 2) begin
      chk("t5_wrap", got5_q[0], '0);
      chk("t5_next", got5_q[1], AW5'(1));
    end

    // 6: asynchronous reset with groups in flight
    got_q.delete();
    out_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, 2, 1);
      tick();
    end
    drive(0, 0, 0, 0);
    repeat (8) tick();
    chk("t6_pre_val", out_val, 1'b1);
    chk("t6_pre_rdy", issue_rdy, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_val", out_val, 1'b0);
    chk("t6_rst_dat", out_data, '0);
    chk("t6_rst_rdy", issue_rdy, 1'b1);
    exp_q.delete();
    gsum = '0;
    outst = 0;
    hold_pend = 1'b0;
    got_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_rdy = 1'b1;
    tick();
    drive(1, 2, 3, 1); tick();
    drive(0, 0, 0, 0);
    wait_got(1, 30);
    chk_got("t6_after", 0, 6);

    // Randomised traffic with bursts of downstream stall
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom), int'($urandom),
            ($urandom_range(0, 2) == 0));
      out_rdy = ((n % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(0, 0, 0, 0);
    out_rdy = 1'b1;
    repeat (30) tick();
    chk("drain_exp_empty", exp_q.size(), 0);
    chk("drain_out_val", out_val, 1'b0);
    chk("drain_rdy", issue_rdy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
